mem_port_arbiter: RTL and testbench

Shares one single-port, synchronous-read SRAM between the fetch stage (instruction reads) and the memory stage (data loads/stores). Sits between the IF/MEM pipeline stages and the unified memory. Grants at most one access per cycle, data priority by default, with a starvation guard for fetch. Routes each one-cycle-latency response back to the requester that issued it, and can squash an in-flight fetch response on redirect.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-port, one-cycle-latency SRAM.
// Define ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_cancel,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_INST = 2'd1,
        SRC_DATA = 2'd2
    } src_e;

    src_e resp_src;
    src_e resp_src_nxt;
    logic grant_i;
    logic grant_d;
    logic force_inst;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;

    // Counts cycles fetch lost to data; saturates at the limit.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (grant_i || !inst_req) begin
            starve_cnt_nxt = '0;
        end else if (data_req && starve_cnt != STARVE_LIM) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign force_inst = inst_req && (starve_cnt == STARVE_LIM);
`else
    assign force_inst = 1'b0;
`endif

    assign grant_d = !rst && data_req && !force_inst;
    assign grant_i = !rst && inst_req && !grant_d;

    assign inst_addr_ok = grant_i;
    assign data_addr_ok = grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_src <= SRC_NONE;
        end else begin
            resp_src <= resp_src_nxt;
        end
    end

    always_comb begin
        resp_src_nxt = SRC_NONE;
        sram_en      = grant_i || grant_d;
        sram_we      = '0;
        sram_addr    = '0;
        sram_wdata   = '0;
        if (grant_d) begin
            resp_src_nxt = SRC_DATA;
            sram_addr    = data_addr;
            sram_wdata   = data_wdata;
            if (data_wr) begin
                sram_we = data_wstrb;
            end
        end else if (grant_i) begin
            resp_src_nxt = SRC_INST;
            sram_addr    = inst_addr;
        end
    end

    // A reset landing on the response cycle drops that response.
    assign inst_data_ok = !rst && (resp_src == SRC_INST) && !inst_cancel;
    assign data_data_ok = !rst && (resp_src == SRC_DATA);

    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-writable SRAM model.
// Expectations follow ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req),
        .data_wr(data_wr),
        .data_wstrb(data_wstrb),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .sram_en(sram_en),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM, word indexed by addr[9:2].
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[sram_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = '0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = '0;
        data_addr   = '0;
        data_wdata  = '0;
    endtask

    logic exp_i [10];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0280_0000;
        mem[2]    = 32'hA0A0_A0A0;
        mem[3]    = 32'hB0B0_B0B0;
        mem[8'h40] = 32'h1122_3344;
        sram_rdata = '0;
        idle();
        rst       = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0000;
        data_req  = 1'b1;
        data_addr = 32'h0000_0200;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
            chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
            chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
            chk("rst_sram_en", 32'(sram_en), 32'd0);
            chk("rst_sram_we", 32'(sram_we), 32'd0);
            chk("rst_sram_addr", sram_addr, 32'd0);
            tick();
        end

        rst = 1'b0;
        @(negedge clk);
        chk("rel_data_first", 32'(data_addr_ok), 32'd1);
        chk("rel_inst_wait", 32'(inst_addr_ok), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("rel_data_resp", 32'(data_data_ok), 32'd1);
        chk("idle_sram_en", 32'(sram_en), 32'd0);
        chk("idle_sram_addr", sram_addr, 32'd0);
        chk("idle_sram_wdata", sram_wdata, 32'd0);

        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0000;
        @(negedge clk);
        chk("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("fetch_sram_addr", sram_addr, 32'h1c00_0000);
        chk("fetch_sram_we", 32'(sram_we), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("fetch_data_ok", 32'(inst_data_ok), 32'd1);
        chk("fetch_rdata", inst_rdata, 32'h0280_0000);
        chk("fetch_no_data_ok", 32'(data_data_ok), 32'd0);

        tick();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h0000_0100;
        data_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("st_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("st_sram_we", 32'(sram_we), 32'h3);
        chk("st_sram_wdata", sram_wdata, 32'hAABB_CCDD);
        chk("st_sram_addr", sram_addr, 32'h100);
        tick();
        data_wr    = 1'b0;
        data_wstrb = 4'b0000;
        data_wdata = '0;
        @(negedge clk);
        chk("st_done", 32'(data_data_ok), 32'd1);
        chk("ld_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("ld_sram_we", 32'(sram_we), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("ld_data_ok", 32'(data_data_ok), 32'd1);
        chk("ld_low_half", {16'h0, data_rdata[15:0]}, 32'h0000_CCDD);
        chk("ld_word", data_rdata, 32'h1122_CCDD);

`ifdef ARB_STARVE_GUARD_EN
        for (int c = 0; c < 10; c++) exp_i[c] = (c == 4 || c == 9);
`else
        for (int c = 0; c < 10; c++) exp_i[c] = 1'b0;
`endif
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0004;
        data_req  = 1'b1;
        data_addr = 32'h0000_0104;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("cont_i%0d", c), 32'(inst_addr_ok), 32'(exp_i[c]));
            chk($sformatf("cont_d%0d", c), 32'(data_addr_ok), 32'(!exp_i[c]));
            tick();
        end
        idle();

        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0008;
        @(negedge clk);
        chk("cx_a_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_addr   = 32'h1c00_000c;
        inst_cancel = 1'b1;
        @(negedge clk);
        chk("cx_a_squashed", 32'(inst_data_ok), 32'd0);
        chk("cx_b_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("cx_b_data_ok", 32'(inst_data_ok), 32'd1);
        chk("cx_b_rdata", inst_rdata, 32'hB0B0_B0B0);

        tick();
        data_req  = 1'b1;
        data_addr = 32'h0000_0100;
        @(negedge clk);
        chk("cxd_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        idle();
        inst_cancel = 1'b1;
        @(negedge clk);
        chk("cxd_data_ok", 32'(data_data_ok), 32'd1);
        chk("cxd_no_inst_ok", 32'(inst_data_ok), 32'd0);

        tick();
        idle();
        data_req  = 1'b1;
        data_addr = 32'h0000_0100;
        @(negedge clk);
        chk("mr_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_c1_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_c2_data_ok", 32'(data_data_ok), 32'd0);
        chk("mr_c2_inst_ok", 32'(inst_data_ok), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
